cv_copy_coord: RTL and testbench

- Coordinate and bounds generator for VRAM-to-VRAM copy (CV) commands.
- Latches the copy rectangle and tracks the current source/destination 32-bit pixel pair and line.
- Sits directly upstream of the CV copy-state sequencer. It supplies the sequencer's alignment flags, line-last flags and end-of-rectangle flag, and applies the sequencer's X/Y step codes.
- Drives the VRAM word addresses for the read and write ports.

---
 rtl/cv_copy_coord_if.sv | 41 ++++
 rtl/cv_copy_coord.sv | 114 +++++++++++
 tb/tb_cv_copy_coord.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cv_copy_coord_if.sv
// Load/step handshake between the CV copy-state sequencer and the coordinate
// generator, plus the flags and VRAM word addresses flowing back.
interface cv_copy_coord_if #(
   parameter int XW = 10,
   parameter int YW = 9
);
   logic                 i_load;
   logic [XW-1:0]        i_srcX;
   logic [YW-1:0]        i_srcY;
   logic [XW-1:0]        i_dstX;
   logic [YW-1:0]        i_dstY;
   logic [XW:0]          i_width;
   logic [YW:0]          i_height;
   logic [2:0]           i_nextX;
   logic [2:0]           i_nextY;
   logic                 i_exit;

   logic                 o_active;
   logic                 o_isWidthNot1;
   logic                 o_xb_0;
   logic                 o_wb_0;
   logic                 o_currPairIsLineLast;
   logic                 o_nextPairIsLineLast;
   logic                 o_endVertical;
   logic [XW+YW-2:0]     o_srcAddr;
   logic [XW+YW-2:0]     o_dstAddr;

   modport master (
      output i_load, i_srcX, i_srcY, i_dstX, i_dstY, i_width, i_height,
             i_nextX, i_nextY, i_exit,
      input  o_active, o_isWidthNot1, o_xb_0, o_wb_0, o_currPairIsLineLast,
             o_nextPairIsLineLast, o_endVertical, o_srcAddr, o_dstAddr
   );

   modport slave (
      input  i_load, i_srcX, i_srcY, i_dstX, i_dstY, i_width, i_height,
             i_nextX, i_nextY, i_exit,
      output o_active, o_isWidthNot1, o_xb_0, o_wb_0, o_currPairIsLineLast,
             o_nextPairIsLineLast, o_endVertical, o_srcAddr, o_dstAddr
   );
endinterface

// File: rtl/cv_copy_coord.sv
// Coordinate/bounds generator for VRAM-to-VRAM copies: latches the rectangle,
// walks 32-bit pixel pairs and lines under sequencer control, emits addresses.
module cv_copy_coord #(
   parameter int XW = 10,
   parameter int YW = 9
) (
   input  logic              clk,
   input  logic              rst,
   cv_copy_coord_if.slave    bus
);
   localparam logic [2:0] X_NEXT  = 3'd1;
   localparam logic [2:0] X_START = 3'd6;
   localparam logic [2:0] Y_NEXT  = 3'd4;
   localparam logic [2:0] Y_ZERO  = 3'd6;

   // Bounds are kept as "last index" (P-1, H-1) so zeroed state reads as a
   // one-pair, one-line rectangle and the last-flags rest at 1.
   typedef struct packed {
      logic [XW-1:0] src_x;
      logic [YW-1:0] src_y;
      logic [XW-1:0] dst_x;
      logic [YW-1:0] dst_y;
      logic [XW-1:0] pair_last;
      logic [YW-1:0] line_last;
      logic          xb_0;
      logic          wb_0;
      logic          w_not1;
   } rect_t;

   rect_t          rect_q, rect_d;
   logic           active_q, active_d;
   logic [XW-1:0]  pair_q, pair_d;
   logic [YW-1:0]  line_q, line_d;

   logic [XW:0]    w_dec;
   logic [YW:0]    h_dec;
   logic [XW-1:0]  w_m1;
   logic [XW:0]    p_sum;

   // Effective W-1 / H-1 wrap a raw 0 to the full VRAM extent.
   always_comb begin
      w_dec = bus.i_width - (XW+1)'(1);
      h_dec = bus.i_height - (YW+1)'(1);
      w_m1  = w_dec[XW-1:0];
      p_sum = {1'b0, w_m1} + {{XW{1'b0}}, bus.i_srcX[0]};
   end

   always_comb begin
      rect_d   = rect_q;
      active_d = active_q;
      pair_d   = pair_q;
      line_d   = line_q;
      if (bus.i_load) begin
         rect_d.src_x     = bus.i_srcX;
         rect_d.src_y     = bus.i_srcY;
         rect_d.dst_x     = bus.i_dstX;
         rect_d.dst_y     = bus.i_dstY;
         rect_d.pair_last = p_sum[XW:1];
         rect_d.line_last = h_dec[YW-1:0];
         rect_d.xb_0      = bus.i_srcX[0];
         rect_d.wb_0      = ~w_m1[0];
         rect_d.w_not1    = (w_m1 != '0);
         active_d         = 1'b1;
         pair_d           = '0;
         line_d           = '0;
      end else begin
         if (bus.i_exit) active_d = 1'b0;
         if (active_q) begin
            if (bus.i_nextX == X_NEXT)       pair_d = pair_q + XW'(1);
            else if (bus.i_nextX == X_START) pair_d = '0;
            if (bus.i_nextY == Y_NEXT) line_d = line_q + YW'(1);
            else if (bus.i_nextY == Y_ZERO) begin
               line_d = '0;
               pair_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rect_q   <= '0;
         active_q <= 1'b0;
         pair_q   <= '0;
         line_q   <= '0;
      end else begin
         rect_q   <= rect_d;
         active_q <= active_d;
         pair_q   <= pair_d;
         line_q   <= line_d;
      end
   end

   logic [XW-1:0] src_pair, dst_pair;
   logic [YW-1:0] src_line, dst_line;

   always_comb begin
      src_pair = {1'b0, rect_q.src_x[XW-1:1]} + pair_q;
      dst_pair = {1'b0, rect_q.dst_x[XW-1:1]} + pair_q;
      src_line = rect_q.src_y + line_q;
      dst_line = rect_q.dst_y + line_q;

      bus.o_active             = active_q;
      bus.o_isWidthNot1        = rect_q.w_not1;
      bus.o_xb_0               = rect_q.xb_0;
      bus.o_wb_0               = rect_q.wb_0;
      bus.o_currPairIsLineLast = (pair_q == rect_q.pair_last);
      bus.o_nextPairIsLineLast = (rect_q.pair_last != '0) &&
                                 (pair_q == rect_q.pair_last - XW'(1));
      bus.o_endVertical        = (line_q == rect_q.line_last);
      bus.o_srcAddr            = {src_line, src_pair[XW-2:0]};
      bus.o_dstAddr            = {dst_line, dst_pair[XW-2:0]};
   end
endmodule

// File: tb/tb_cv_copy_coord.sv
// Bench for cv_copy_coord: directed rectangle scenarios plus constrained-random
// load/step/exit traffic compared every cycle against an integer model.
module tb_cv_copy_coord;
   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   chk_en   = 0;

   cv_copy_coord_if bus();
   cv_copy_coord dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(string nm, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endfunction

   // ---------------- behavioural model (plain integers) ----------------
   int m_sx, m_sy, m_dx, m_dy, m_W, m_H, m_P, m_pair, m_line;
   bit m_act;

   function automatic int eff_w(int raw); return ((raw - 1) & 1023) + 1; endfunction
   function automatic int eff_h(int raw); return ((raw - 1) & 511) + 1; endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_act <= 0; m_sx <= 0; m_sy <= 0; m_dx <= 0; m_dy <= 0;
         m_W <= 0; m_H <= 0; m_P <= 0; m_pair <= 0; m_line <= 0;
      end else if (bus.i_load) begin
         m_act  <= 1;
         m_sx   <= int'(bus.i_srcX); m_sy <= int'(bus.i_srcY);
         m_dx   <= int'(bus.i_dstX); m_dy <= int'(bus.i_dstY);
         m_W    <= eff_w(int'(bus.i_width));
         m_H    <= eff_h(int'(bus.i_height));
         m_P    <= (int'(bus.i_srcX[0]) + eff_w(int'(bus.i_width)) + 1) / 2;
         m_pair <= 0; m_line <= 0;
      end else begin
         if (bus.i_exit) m_act <= 0;
         if (m_act) begin
            if (bus.i_nextY == 3'd6) begin
               m_pair <= 0; m_line <= 0;
            end else begin
               if (bus.i_nextY == 3'd4) m_line <= m_line + 1;
               if (bus.i_nextX == 3'd1) m_pair <= m_pair + 1;
               else if (bus.i_nextX == 3'd6) m_pair <= 0;
            end
         end
      end
   end

   // Every-cycle compare; m_W/m_P/m_H == 0 means nothing latched since reset,
   // where the last-flags read 1 and the width flags read 0.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("active", int'(bus.o_active), int'(m_act));
         chk("isWidthNot1", int'(bus.o_isWidthNot1), int'(m_W > 1));
         chk("xb_0", int'(bus.o_xb_0), m_sx % 2);
         chk("wb_0", int'(bus.o_wb_0), m_W % 2);
         chk("currLast", int'(bus.o_currPairIsLineLast),
             int'(m_P == 0 || m_pair == m_P - 1));
         chk("nextLast", int'(bus.o_nextPairIsLineLast),
             int'(m_P >= 2 && m_pair == m_P - 2));
         chk("endVertical", int'(bus.o_endVertical),
             int'(m_H == 0 || m_line == m_H - 1));
         chk("srcAddr", int'(bus.o_srcAddr),
             ((m_sy + m_line) % 512) * 512 + ((m_sx / 2 + m_pair) % 512));
         chk("dstAddr", int'(bus.o_dstAddr),
             ((m_dy + m_line) % 512) * 512 + ((m_dx / 2 + m_pair) % 512));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_in(bit ld, int sx, int sy, int dx, int dy, int w, int h,
                         int nx, int ny, bit ex);
      bus.i_load = ld;
      bus.i_srcX = 10'(sx); bus.i_srcY = 9'(sy);
      bus.i_dstX = 10'(dx); bus.i_dstY = 9'(dy);
      bus.i_width = 11'(w); bus.i_height = 10'(h);
      bus.i_nextX = 3'(nx); bus.i_nextY = 3'(ny);
      bus.i_exit = ex;
   endtask

   task automatic step(int nx, int ny, bit ex);
      set_in(0, 0, 0, 0, 0, 0, 0, nx, ny, ex);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      step(0, 0, 0);
      tick(); tick();
      rst = 1'b0;
      chk_en = 1;
      tick();
      chk("rst active", int'(bus.o_active), 0);
      chk("rst srcAddr", int'(bus.o_srcAddr), 0);
      chk("rst currLast", int'(bus.o_currPairIsLineLast), 1);
      chk("rst endVertical", int'(bus.o_endVertical), 1);
      chk("rst isWidthNot1", int'(bus.o_isWidthNot1), 0);

      // srcX=4, W=6, H=2 -> 3 pairs
      set_in(1, 4, 0, 0, 0, 6, 2, 0, 0, 0); tick();
      step(0, 0, 0);
      chk("p3 c0 curr", int'(bus.o_currPairIsLineLast), 0);
      chk("p3 c0 next", int'(bus.o_nextPairIsLineLast), 0);
      step(1, 0, 0); tick();
      chk("p3 c1 curr", int'(bus.o_currPairIsLineLast), 0);
      chk("p3 c1 next", int'(bus.o_nextPairIsLineLast), 1);
      step(1, 0, 0); tick();
      chk("p3 c2 curr", int'(bus.o_currPairIsLineLast), 1);
      step(6, 4, 0); tick();
      chk("p3 line1 endV", int'(bus.o_endVertical), 1);
      chk("p3 line1 src", int'(bus.o_srcAddr), 1 * 512 + 2);

      // srcX=1, W=1 -> single pair
      set_in(1, 1, 0, 0, 0, 1, 1, 0, 0, 0); tick();
      chk("w1 isWidthNot1", int'(bus.o_isWidthNot1), 0);
      chk("w1 xb_0", int'(bus.o_xb_0), 1);
      chk("w1 wb_0", int'(bus.o_wb_0), 1);
      chk("w1 curr", int'(bus.o_currPairIsLineLast), 1);
      chk("w1 next", int'(bus.o_nextPairIsLineLast), 0);

      // Full-width wrapping rectangle: 513 pairs
      set_in(1, 1023, 511, 0, 0, 0, 2, 0, 0, 0); tick();
      chk("wrap P", m_P, 513);
      chk("wrap src0", int'(bus.o_srcAddr), 511 * 512 + 511);
      step(1, 0, 0); tick();
      chk("wrap src1", int'(bus.o_srcAddr), 511 * 512 + 0);
      step(6, 4, 0); tick();
      chk("wrap src2", int'(bus.o_srcAddr), 0 * 512 + 511);

      // Reload mid-command with simultaneous X step and exit
      set_in(1, 10, 20, 30, 40, 8, 3, 1, 0, 1); tick();
      chk("reload active", int'(bus.o_active), 1);
      chk("reload src", int'(bus.o_srcAddr), 20 * 512 + 5);
      chk("reload dst", int'(bus.o_dstAddr), 40 * 512 + 15);
      step(1, 0, 1); tick();
      chk("exit active", int'(bus.o_active), 0);
      chk("exit src", int'(bus.o_srcAddr), 20 * 512 + 6);
      step(1, 4, 0); tick();
      chk("idle step src", int'(bus.o_srcAddr), 20 * 512 + 6);

      // Reset mid-command, then steps while inactive
      set_in(1, 100, 7, 50, 9, 40, 5, 0, 0, 0); tick();
      step(1, 4, 0); tick();
      rst = 1'b1; step(1, 4, 0); tick();
      rst = 1'b0; tick();
      chk("mid rst active", int'(bus.o_active), 0);
      chk("mid rst src", int'(bus.o_srcAddr), 0);
      chk("mid rst curr", int'(bus.o_currPairIsLineLast), 1);
      chk("mid rst endV", int'(bus.o_endVertical), 1);

      // Constrained random traffic: steps never cross the rectangle bounds
      for (int i = 0; i < 4000; i++) begin
         int nx, ny, w, h;
         bit ld, ex;
         ld = ($urandom_range(0, 19) == 0);
         ex = ($urandom_range(0, 39) == 0);
         nx = $urandom_range(0, 7);
         ny = $urandom_range(0, 7);
         if ($urandom_range(0, 3) != 0) nx = 1;
         if ($urandom_range(0, 5) == 0) ny = 4;
         if (nx == 1 && m_pair >= m_P - 1) nx = 0;
         if (ny == 4 && m_line >= m_H - 1) ny = 0;
         w = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2047) : $urandom_range(0, 9);
         h = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 1023) : $urandom_range(0, 5);
         set_in(ld, $urandom_range(0, 1023), $urandom_range(0, 511),
                $urandom_range(0, 1023), $urandom_range(0, 511), w, h, nx, ny, ex);
         rst = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0;
      step(0, 0, 0);
      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
